// File: rtl/lc3_ctrl_pkg.sv
// Shared types and opcode classifiers for the LC3 pipeline controller.
package lc3_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011,
    OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
    OP_RTI = 4'b1000, OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011,
    OP_JMP = 4'b1100, OP_RES = 4'b1101, OP_LEA = 4'b1110, OP_TRAP = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    MS_READ = 2'd0, MS_IND = 2'd1, MS_WRITE = 2'd2, MS_IDLE = 2'd3
  } mem_state_t;

  typedef enum logic [1:0] {
    ST_RUN, ST_MEM_IND, ST_MEM_RD, ST_MEM_WR
  } ctrl_state_t;

  localparam logic [2:0] FILL_DONE = 3'd4;

  function automatic logic is_alu_op(input logic [3:0] op);
    opcode_t o;
    o = opcode_t'(op);
    return (o == OP_ADD) || (o == OP_AND) || (o == OP_NOT);
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    opcode_t o;
    o = opcode_t'(op);
    return (o == OP_LD) || (o == OP_LDR) || (o == OP_LDI) ||
           (o == OP_ST) || (o == OP_STR) || (o == OP_STI);
  endfunction

  function automatic logic is_ctrl_op(input logic [3:0] op);
    opcode_t o;
    o = opcode_t'(op);
    return (o == OP_BR) || (o == OP_JMP);
  endfunction

  // Instructions that produce a register result directly from execute.
  function automatic logic is_wb_op(input logic [3:0] op);
    return is_alu_op(op) || (opcode_t'(op) == OP_LEA);
  endfunction

endpackage

// File: rtl/lc3_pipe_controller_if.sv
// Status/enable bundle between the LC3 pipeline datapath and its controller.
interface lc3_pipe_controller_if;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] IMem_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  NZP;
  logic [2:0]  psr;
  logic        enable_fetch;
  logic        enable_updatePC;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;

  modport slave (
    input  complete_instr, complete_data, IMem_dout, IR, IR_Exec, NZP, psr,
    output enable_fetch, enable_updatePC, enable_decode, enable_execute,
           enable_writeback, br_taken, mem_state,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
  );

  modport master (
    output complete_instr, complete_data, IMem_dout, IR, IR_Exec, NZP, psr,
    input  enable_fetch, enable_updatePC, enable_decode, enable_execute,
           enable_writeback, br_taken, mem_state,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
  );
endinterface

// File: rtl/lc3_hazard_detect.sv
// Source-register match of the decoding ALU op against the executing ALU result
// and the most recently completed load.
module lc3_hazard_detect
  import lc3_ctrl_pkg::*;
(
  input  logic [3:0] dec_op_i,
  input  logic [2:0] dec_sr1_i,
  input  logic [2:0] dec_sr2_i,
  input  logic       dec_imm_i,
  input  logic [3:0] ex_op_i,
  input  logic [2:0] ex_dst_i,
  input  logic       ld_vld_i,
  input  logic [2:0] ld_dst_i,
  output logic       alu_1_o,
  output logic       alu_2_o,
  output logic       mem_1_o,
  output logic       mem_2_o
);
  logic dec_alu, ex_alu;

  assign dec_alu = is_alu_op(dec_op_i);
  assign ex_alu  = is_alu_op(ex_op_i);

  // SR2 is only a register operand when the immediate flag is clear.
  assign alu_1_o = dec_alu && ex_alu && (ex_dst_i == dec_sr1_i);
  assign alu_2_o = dec_alu && ex_alu && !dec_imm_i && (ex_dst_i == dec_sr2_i);
  assign mem_1_o = dec_alu && ld_vld_i && (ld_dst_i == dec_sr1_i);
  assign mem_2_o = dec_alu && ld_vld_i && !dec_imm_i && (ld_dst_i == dec_sr2_i);
endmodule

// File: rtl/lc3_pipe_controller.sv
// LC3 five-stage pipeline sequencer: stage enables, memory/branch stalls, bypass selects.
// Define LC3_CTRL_BYPASS_EN to forward on register matches instead of stalling decode.
module lc3_pipe_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned BR_BUBBLE = 3
) (
  input logic                  clock,
  input logic                  reset,
  lc3_pipe_controller_if.slave bus
);
  localparam int unsigned BW = $clog2(BR_BUBBLE + 1);

  ctrl_state_t   state_q, state_d;
  logic [2:0]    fill_q, fill_d;
  logic [BW-1:0] bub_q, bub_d;
  logic          res_q, res_d, jmp_q, jmp_d;
  logic          exec_q, exec_d, haz_q, haz_d;
  logic          ld_vld_q, ld_vld_d;
  logic [2:0]    ld_dst_q, ld_dst_d, mem_dst_q, mem_dst_d;
  logic          mem_st_q, mem_st_d;

  logic       f1, f2, f3, bub_act, hz_ok, haz_stall;
  logic       m_alu1, m_alu2, m_mem1, m_mem2;
  logic       en_fetch, en_upc, en_dec, en_exe, en_wb, br_tk;
  mem_state_t ms;
  opcode_t    op_x;

  assign f1      = (fill_q >= 3'd1);
  assign f2      = (fill_q >= 3'd2);
  assign f3      = (fill_q >= 3'd3);
  assign bub_act = (bub_q != '0);
  assign hz_ok   = (state_q == ST_RUN) && f3;
  assign op_x    = opcode_t'(bus.IR_Exec[15:12]);

  lc3_hazard_detect u_hz (
    .dec_op_i  (bus.IR[15:12]),
    .dec_sr1_i (bus.IR[8:6]),
    .dec_sr2_i (bus.IR[2:0]),
    .dec_imm_i (bus.IR[5]),
    .ex_op_i   (bus.IR_Exec[15:12]),
    .ex_dst_i  (bus.IR_Exec[11:9]),
    .ld_vld_i  (ld_vld_q),
    .ld_dst_i  (ld_dst_q),
    .alu_1_o   (m_alu1),
    .alu_2_o   (m_alu2),
    .mem_1_o   (m_mem1),
    .mem_2_o   (m_mem2)
  );

`ifdef LC3_CTRL_BYPASS_EN
  assign haz_stall        = 1'b0;
  assign bus.bypass_alu_1 = hz_ok && m_alu1;
  assign bus.bypass_alu_2 = hz_ok && m_alu2;
  assign bus.bypass_mem_1 = hz_ok && m_mem1;
  assign bus.bypass_mem_2 = hz_ok && m_mem2;
`else
  // A held match stalls only once; haz_q lets the dependent op through next cycle.
  assign haz_stall        = hz_ok && (m_alu1 || m_alu2 || m_mem1 || m_mem2) && !haz_q;
  assign bus.bypass_alu_1 = 1'b0;
  assign bus.bypass_alu_2 = 1'b0;
  assign bus.bypass_mem_1 = 1'b0;
  assign bus.bypass_mem_2 = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    fill_d    = (fill_q < FILL_DONE) ? fill_q + 3'd1 : fill_q;
    bub_d     = bub_q;
    res_d     = res_q;
    jmp_d     = jmp_q;
    mem_st_d  = mem_st_q;
    mem_dst_d = mem_dst_q;
    ld_vld_d  = 1'b0;
    ld_dst_d  = ld_dst_q;
    en_fetch  = 1'b0;
    en_upc    = 1'b0;
    en_dec    = 1'b0;
    en_exe    = 1'b0;
    en_wb     = 1'b0;
    br_tk     = 1'b0;
    ms        = MS_IDLE;
    case (state_q)
      ST_RUN: begin
        en_exe   = f3;
        en_fetch = f1 && !bub_act && !haz_stall;
        en_upc   = f1 && (res_q || (!bub_act && !haz_stall && bus.complete_instr));
        en_dec   = f2 && !haz_stall && (bub_act || bus.complete_instr);
        en_wb    = exec_q && is_wb_op(bus.IR_Exec[15:12]);
        br_tk    = res_q && (jmp_q || (|(bus.NZP & bus.psr)));
        res_d    = bub_act && (bub_q == BW'(1));
        if (bub_act) begin
          bub_d = bub_q - BW'(1);
        end else if (en_fetch && is_ctrl_op(bus.IMem_dout[15:12])) begin
          bub_d = BW'(BR_BUBBLE);
          jmp_d = (bus.IMem_dout[15:12] == OP_JMP);
        end
        // Capture the memory op on entry; IR_Exec moves on once execute fires.
        if (en_exe) begin
          mem_st_d  = (op_x == OP_STI);
          mem_dst_d = bus.IR_Exec[11:9];
          case (op_x)
            OP_LDI, OP_STI: state_d = ST_MEM_IND;
            OP_LD,  OP_LDR: state_d = ST_MEM_RD;
            OP_ST,  OP_STR: state_d = ST_MEM_WR;
            default:        state_d = ST_RUN;
          endcase
        end
      end
      ST_MEM_IND: begin
        ms = MS_IND;
        if (bus.complete_data) state_d = mem_st_q ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        ms = MS_READ;
        if (bus.complete_data) begin
          en_wb    = 1'b1;
          ld_vld_d = 1'b1;
          ld_dst_d = mem_dst_q;
          state_d  = ST_RUN;
        end
      end
      ST_MEM_WR: begin
        ms = MS_WRITE;
        if (bus.complete_data) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign exec_d = en_exe;
  assign haz_d  = haz_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RUN;
      fill_q    <= '0;
      bub_q     <= '0;
      res_q     <= 1'b0;
      jmp_q     <= 1'b0;
      exec_q    <= 1'b0;
      haz_q     <= 1'b0;
      ld_vld_q  <= 1'b0;
      ld_dst_q  <= '0;
      mem_dst_q <= '0;
      mem_st_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      bub_q     <= bub_d;
      res_q     <= res_d;
      jmp_q     <= jmp_d;
      exec_q    <= exec_d;
      haz_q     <= haz_d;
      ld_vld_q  <= ld_vld_d;
      ld_dst_q  <= ld_dst_d;
      mem_dst_q <= mem_dst_d;
      mem_st_q  <= mem_st_d;
    end
  end

  assign bus.enable_fetch     = en_fetch;
  assign bus.enable_updatePC  = en_upc;
  assign bus.enable_decode    = en_dec;
  assign bus.enable_execute   = en_exe;
  assign bus.enable_writeback = en_wb;
  assign bus.br_taken         = br_tk;
  assign bus.mem_state        = ms;
endmodule
